pc_redirect_unit: RTL and testbench

Fetch-side program-counter and control-flow redirect stage for the RAT pipeline, sitting directly downstream of the branch calculator. It consumes the execute-stage branch type and branch-taken decision, maintains the fetch PC, and holds a hardware return-address stack for CALL/RET/RETID/RETIE. It also owns the interrupt-enable bit and interrupt vectoring, and drives the pipeline flush that squashes wrong-path instructions after every redirect.

---
 rtl/pc_redirect_unit.sv | 96 +++++++++
 tb/tb_pc_redirect_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC, return-address stack, interrupt vectoring and post-redirect flush.
module pc_redirect_unit #(
    parameter int PC_WIDTH = 10,
    parameter int RAS_DEPTH = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter logic [PC_WIDTH-1:0] INT_VECTOR = PC_WIDTH'(10'h3FF)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                STALL,
    input  logic                EX_VALID,
    input  logic [PC_WIDTH-1:0] EX_PC,
    input  logic [3:0]          BRANCH_TYPE,
    input  logic                BRANCH_TAKEN,
    input  logic [PC_WIDTH-1:0] BRANCH_TARGET,
    input  logic                SEI,
    input  logic                CLI,
    input  logic                INT_REQ,
    output logic [PC_WIDTH-1:0] PC,
    output logic                FLUSH,
    output logic                I_SET,
    output logic                INT_ACK,
    output logic                RAS_OVERFLOW,
    output logic                RAS_UNDERFLOW
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0] state;
    logic [2:0] cnt;
    logic [CW-1:0] count;
    logic [PC_WIDTH-1:0] ras [RAS_DEPTH];
    logic act, is_jmp, is_ret, redirect, take_int, push, pop, full, empty, iset_next;
    logic [PC_WIDTH-1:0] top, ret_addr, pc_next;

    always_comb begin
        act = EX_VALID && !STALL && state == ST_RUN;
        is_jmp = BRANCH_TYPE >= 4'd1 && BRANCH_TYPE <= 4'd6;
        is_ret = BRANCH_TYPE >= 4'd7 && BRANCH_TYPE <= 4'd9;
        redirect = act && BRANCH_TAKEN && (is_jmp || is_ret);
        take_int = act && !redirect && I_SET && INT_REQ;
        push = take_int || (redirect && BRANCH_TYPE == 4'd6);
        pop = redirect && is_ret;
        full = count == CW'(RAS_DEPTH);
        empty = count == '0;
        top = ras[count[AW-1:0] - AW'(1)];
        ret_addr = EX_PC + PC_WIDTH'(1);
        pc_next = pop ? (empty ? '0 : top) :
                  redirect ? BRANCH_TARGET :
                  take_int ? INT_VECTOR : PC + PC_WIDTH'(1);
        // return-with-interrupt-control outranks SEI/CLI issued alongside it
        iset_next = !act ? I_SET :
                    take_int ? 1'b0 :
                    (redirect && BRANCH_TYPE == 4'd8) ? 1'b0 :
                    (redirect && BRANCH_TYPE == 4'd9) ? 1'b1 :
                    CLI ? 1'b0 : SEI ? 1'b1 : I_SET;
    end

    assign FLUSH = state == ST_FLUSH;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PC <= '0;
            state <= ST_RUN;
            cnt <= '0;
            count <= '0;
            I_SET <= 1'b0;
            INT_ACK <= 1'b0;
            RAS_OVERFLOW <= 1'b0;
            RAS_UNDERFLOW <= 1'b0;
        end else if (STALL) begin
            INT_ACK <= 1'b0;
        end else begin
            PC <= pc_next;
            I_SET <= iset_next;
            INT_ACK <= take_int;
            if (push && full) RAS_OVERFLOW <= 1'b1;
            if (pop && empty) RAS_UNDERFLOW <= 1'b1;
            count <= (push && !full) ? count + CW'(1) : (pop && !empty) ? count - CW'(1) : count;
            if (redirect || take_int) begin
                state <= ST_FLUSH;
                cnt <= 3'(FLUSH_CYCLES - 1);
            end else if (state == ST_FLUSH) begin
                state <= cnt == '0 ? ST_RUN : ST_FLUSH;
                cnt <= cnt == '0 ? '0 : cnt - 3'd1;
            end
        end
    end

    // entries need no reset: count alone defines what is valid
    always_ff @(posedge CLK) begin
        if (push && !full) ras[count[AW-1:0]] <= ret_addr;
    end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: vector table, directed stack/stall/reset sequences and randomized model check.
module tb_pc_redirect_unit;
    localparam int FC = 2;
    localparam int DEPTH = 8;

    logic CLK = 1'b0, RST = 1'b1;
    logic STALL, EX_VALID, BRANCH_TAKEN, SEI, CLI, INT_REQ;
    logic [9:0] EX_PC, BRANCH_TARGET;
    logic [3:0] BRANCH_TYPE;
    logic [9:0] PC;
    logic FLUSH, I_SET, INT_ACK, RAS_OVERFLOW, RAS_UNDERFLOW;

    int n_cmp = 0;
    int n_err = 0;

    int m_pc, m_left;
    bit m_iset, m_ack, m_ovf, m_unf;
    logic [9:0] m_stack[$];

    typedef struct {
        logic stall, valid;
        logic [9:0] ex_pc;
        logic [3:0] btype;
        logic taken;
        logic [9:0] target;
        logic sei, cli, intr;
        logic [9:0] e_pc;
        logic e_flush, e_iset, e_ack;
    } vec_t;
    vec_t tbl[30];

    pc_redirect_unit dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .EX_VALID(EX_VALID), .EX_PC(EX_PC),
        .BRANCH_TYPE(BRANCH_TYPE), .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
        .SEI(SEI), .CLI(CLI), .INT_REQ(INT_REQ), .PC(PC), .FLUSH(FLUSH), .I_SET(I_SET),
        .INT_ACK(INT_ACK), .RAS_OVERFLOW(RAS_OVERFLOW), .RAS_UNDERFLOW(RAS_UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t v(logic st, logic va, logic [9:0] ep, logic [3:0] bt, logic tk,
                               logic [9:0] tg, logic se, logic cl, logic ir,
                               logic [9:0] xp, logic xf, logic xi, logic xa);
        vec_t r;
        r.stall = st; r.valid = va; r.ex_pc = ep; r.btype = bt; r.taken = tk; r.target = tg;
        r.sei = se; r.cli = cl; r.intr = ir; r.e_pc = xp; r.e_flush = xf; r.e_iset = xi; r.e_ack = xa;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic idle();
        STALL = 0; EX_VALID = 0; EX_PC = 0; BRANCH_TYPE = 0; BRANCH_TAKEN = 0;
        BRANCH_TARGET = 0; SEI = 0; CLI = 0; INT_REQ = 0;
    endtask

    task automatic model_reset();
        m_pc = 0; m_left = 0; m_iset = 0; m_ack = 0; m_ovf = 0; m_unf = 0;
        m_stack.delete();
    endtask

    task automatic model_push(logic [9:0] a);
        if (m_stack.size() == DEPTH) m_ovf = 1;
        else m_stack.push_back(a);
    endtask

    task automatic model_step();
        bit act, redir, intr;
        int t;
        int np;
        if (STALL) begin
            m_ack = 0;
        end else begin
            t = int'(BRANCH_TYPE);
            act = EX_VALID && m_left == 0;
            redir = act && BRANCH_TAKEN && t >= 1 && t <= 9;
            intr = act && !redir && m_iset && INT_REQ;
            np = (m_pc + 1) % 1024;
            if (m_left > 0) m_left--;
            if (redir) begin
                if (t == 6) model_push(EX_PC + 10'd1);
                if (t <= 6) np = int'(BRANCH_TARGET);
                else if (m_stack.size() == 0) begin np = 0; m_unf = 1; end
                else np = int'(m_stack.pop_back());
                if (t == 8) m_iset = 0;
                if (t == 9) m_iset = 1;
            end else if (intr) begin
                model_push(EX_PC + 10'd1);
                np = 'h3FF;
                m_iset = 0;
            end
            if (act && !intr && !(redir && t >= 8)) begin
                if (CLI) m_iset = 0;
                else if (SEI) m_iset = 1;
            end
            if (redir || intr) m_left = FC;
            m_ack = intr;
            m_pc = np;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        RST = 1;
        idle();
        @(posedge CLK);
        #1;
        RST = 0;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        model_reset();
        #1;
        chk("async_reset_pc", PC, 0);
        do_reset();
        chk("reset_pc", PC, 0);
        chk("reset_flush", FLUSH, 0);
        chk("reset_iset", I_SET, 0);
        chk("reset_ack", INT_ACK, 0);
        chk("reset_ovf", RAS_OVERFLOW, 0);
        chk("reset_unf", RAS_UNDERFLOW, 0);

        tbl[0]  = v(0,0,0,0,0,0,0,0,0, 10'h001,0,0,0);
        tbl[1]  = v(0,0,0,0,0,0,0,0,0, 10'h002,0,0,0);
        tbl[2]  = v(0,0,0,0,0,0,0,0,0, 10'h003,0,0,0);
        tbl[3]  = v(0,0,0,0,0,0,0,0,0, 10'h004,0,0,0);
        tbl[4]  = v(0,1,10'h010,4,1,10'h040,0,0,0, 10'h040,1,0,0);
        tbl[5]  = v(0,1,10'h041,4,1,10'h200,0,0,0, 10'h041,1,0,0);
        tbl[6]  = v(0,0,0,0,0,0,0,0,0, 10'h042,0,0,0);
        tbl[7]  = v(0,1,10'h040,1,0,10'h300,0,0,0, 10'h043,0,0,0);
        tbl[8]  = v(0,1,10'h020,6,1,10'h100,0,0,0, 10'h100,1,0,0);
        tbl[9]  = v(0,0,0,0,0,0,0,0,0, 10'h101,1,0,0);
        tbl[10] = v(0,0,0,0,0,0,0,0,0, 10'h102,0,0,0);
        tbl[11] = v(0,1,10'h101,9,1,0,0,0,0, 10'h021,1,1,0);
        tbl[12] = v(0,0,0,0,0,0,0,0,0, 10'h022,1,1,0);
        tbl[13] = v(0,0,0,0,0,0,0,0,0, 10'h023,0,1,0);
        tbl[14] = v(0,1,10'h030,0,0,0,0,0,1, 10'h3FF,1,0,1);
        tbl[15] = v(0,0,0,0,0,0,0,0,1, 10'h000,1,0,0);
        tbl[16] = v(0,0,0,0,0,0,0,0,1, 10'h001,0,0,0);
        tbl[17] = v(0,1,10'h3FE,8,1,0,0,0,0, 10'h031,1,0,0);
        tbl[18] = v(0,0,0,0,0,0,0,0,0, 10'h032,1,0,0);
        tbl[19] = v(0,0,0,0,0,0,0,0,0, 10'h033,0,0,0);
        tbl[20] = v(0,1,10'h033,0,0,0,1,0,0, 10'h034,0,1,0);
        tbl[21] = v(0,1,10'h034,0,0,0,1,1,0, 10'h035,0,0,0);
        tbl[22] = v(1,1,10'h035,4,1,10'h111,0,0,0, 10'h035,0,0,0);
        tbl[23] = v(0,1,10'h035,0,0,0,1,0,0, 10'h036,0,1,0);
        tbl[24] = v(0,1,10'h036,0,0,0,1,0,1, 10'h3FF,1,0,1);
        tbl[25] = v(0,0,0,0,0,0,0,0,0, 10'h000,1,0,0);
        tbl[26] = v(0,0,0,0,0,0,0,0,0, 10'h001,0,0,0);
        tbl[27] = v(0,1,10'h001,7,1,0,0,0,0, 10'h037,1,0,0);
        tbl[28] = v(0,0,0,0,0,0,0,0,0, 10'h038,1,0,0);
        tbl[29] = v(0,0,0,0,0,0,0,0,0, 10'h039,0,0,0);

        foreach (tbl[i]) begin
            STALL = tbl[i].stall; EX_VALID = tbl[i].valid; EX_PC = tbl[i].ex_pc;
            BRANCH_TYPE = tbl[i].btype; BRANCH_TAKEN = tbl[i].taken; BRANCH_TARGET = tbl[i].target;
            SEI = tbl[i].sei; CLI = tbl[i].cli; INT_REQ = tbl[i].intr;
            step();
            chk($sformatf("vec%0d_pc", i), PC, tbl[i].e_pc);
            chk($sformatf("vec%0d_flush", i), FLUSH, tbl[i].e_flush);
            chk($sformatf("vec%0d_iset", i), I_SET, tbl[i].e_iset);
            chk($sformatf("vec%0d_ack", i), INT_ACK, tbl[i].e_ack);
            chk($sformatf("vec%0d_flags", i), {RAS_OVERFLOW, RAS_UNDERFLOW}, 0);
        end

        // nine nested calls into an eight-deep stack, then nine returns
        for (int k = 0; k < 9; k++) begin
            idle();
            EX_VALID = 1; BRANCH_TYPE = 6; BRANCH_TAKEN = 1;
            EX_PC = 10'(10'h050 + k); BRANCH_TARGET = 10'(10'h100 + k * 16);
            step();
            chk($sformatf("call%0d_pc", k), PC, 10'h100 + k * 16);
            chk($sformatf("call%0d_ovf", k), RAS_OVERFLOW, k == 8);
            idle();
            step();
            step();
        end
        for (int k = 0; k < 9; k++) begin
            idle();
            EX_VALID = 1; BRANCH_TYPE = 7; BRANCH_TAKEN = 1; EX_PC = 10'h2AA;
            step();
            chk($sformatf("ret%0d_pc", k), PC, k < 8 ? 10'h058 - k : 0);
            chk($sformatf("ret%0d_unf", k), RAS_UNDERFLOW, k == 8);
            idle();
            step();
            step();
        end
        chk("ovf_sticky", RAS_OVERFLOW, 1);

        // stall stretches the flush window
        idle();
        EX_VALID = 1; BRANCH_TYPE = 3; BRANCH_TAKEN = 1; BRANCH_TARGET = 10'h200;
        step();
        chk("stall_br_pc", PC, 10'h200);
        chk("stall_br_flush", FLUSH, 1);
        for (int k = 0; k < 3; k++) begin
            STALL = 1;
            step();
            chk($sformatf("stall%0d_pc", k), PC, 10'h200);
            chk($sformatf("stall%0d_flush", k), FLUSH, 1);
        end
        idle();
        step();
        chk("post_stall1_pc", PC, 10'h201);
        chk("post_stall1_flush", FLUSH, 1);
        step();
        chk("post_stall2_pc", PC, 10'h202);
        chk("post_stall2_flush", FLUSH, 0);

        // asynchronous reset in the middle of a flush
        EX_VALID = 1; BRANCH_TYPE = 5; BRANCH_TAKEN = 1; BRANCH_TARGET = 10'h280;
        step();
        chk("pre_rst_flush", FLUSH, 1);
        idle();
        #2;
        RST = 1;
        #1;
        chk("mid_rst_pc", PC, 0);
        chk("mid_rst_flush", FLUSH, 0);
        chk("mid_rst_iset", I_SET, 0);
        chk("mid_rst_ack", INT_ACK, 0);
        chk("mid_rst_ovf", RAS_OVERFLOW, 0);
        chk("mid_rst_unf", RAS_UNDERFLOW, 0);
        @(posedge CLK);
        #1;
        RST = 0;
        model_reset();
        chk("rst_release_pc", PC, 0);

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            STALL = $urandom_range(0, 99) < 15;
            EX_VALID = $urandom_range(0, 99) < 75;
            EX_PC = 10'($urandom);
            BRANCH_TYPE = r < 16 ? 4'(r) : (r < 18 ? 4'd6 : 4'd7);
            BRANCH_TAKEN = 1'($urandom_range(0, 1));
            BRANCH_TARGET = 10'($urandom);
            SEI = $urandom_range(0, 99) < 15;
            CLI = $urandom_range(0, 99) < 8;
            INT_REQ = $urandom_range(0, 99) < 25;
            step();
            chk("rnd_pc", PC, m_pc);
            chk("rnd_flush", FLUSH, m_left > 0);
            chk("rnd_iset", I_SET, m_iset);
            chk("rnd_ack", INT_ACK, m_ack);
            chk("rnd_ovf", RAS_OVERFLOW, m_ovf);
            chk("rnd_unf", RAS_UNDERFLOW, m_unf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
